// File: rtl/z_mult_booth_ctrl_pkg.sv
// Shared types for the sequential Booth multiplier controller: FSM states,
// operand width and the Booth add/sub/nop select.
package z_mult_booth_ctrl_pkg;

  localparam int MULT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    NOP = 2'd0,
    ADD = 2'd1,
    SUB = 2'd2
  } booth_sel_t;

  // Radix-2 Booth recoding of the pair {Q[0], q_1}.
  function automatic booth_sel_t booth_sel(input logic q0, input logic q_1);
    case ({q0, q_1})
      2'b01:   return ADD;
      2'b10:   return SUB;
      default: return NOP;
    endcase
  endfunction

endpackage

// File: rtl/z_mult_booth_ctrl_step.sv
// One combinational radix-2 Booth step: picks the adder operand from
// {Q[0], q_1} and forms the arithmetic-right-shifted {A, Q, q_1}.
module z_booth_step
  import z_mult_booth_ctrl_pkg::*;
#(
  parameter int WIDTH = MULT_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] q,
  input  logic             q_1,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  output logic [WIDTH-1:0] a_nxt,
  output logic [WIDTH-1:0] q_nxt,
  output logic             q_1_nxt
);

  logic s;

  always_comb begin
    add_b   = '0;
    add_cin = 1'b0;
    case (booth_sel(q[0], q_1))
      ADD: begin
        add_b   = m;
        add_cin = 1'b0;
      end
      SUB: begin
        add_b   = ~m;
        add_cin = 1'b1;
      end
      default: begin
        add_b   = '0;
        add_cin = 1'b0;
      end
    endcase
    // 33rd result bit of the sign-extended add; stays correct for M = -2^31.
    s       = a[WIDTH-1] ^ add_b[WIDTH-1] ^ add_cout;
    a_nxt   = {s, add_sum[WIDTH-1:1]};
    q_nxt   = {add_sum[0], q[WIDTH-1:1]};
    q_1_nxt = q[0];
  end

endmodule

// File: rtl/z_mult_booth_ctrl.sv
// Sequential radix-2 Booth signed 32x32->64 multiplier controller driving the
// shared execute-stage adder. Optional macro: Z_MULT_ZERO_BYPASS_EN.
module z_mult_booth_ctrl
  import z_mult_booth_ctrl_pkg::*;
#(
  parameter int WIDTH = MULT_W,
  parameter int CNT_W = 6
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               overflow,
  output logic               adder_req,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_r, q_r, m_r;
  logic             q1_r;

  logic [WIDTH-1:0] step_b, a_nxt, q_nxt;
  logic             step_cin, q1_nxt;
  logic             run, done, accept, zero_op;

  z_booth_step #(.WIDTH(WIDTH)) u_step (
    .a        (a_r),
    .m        (m_r),
    .q        (q_r),
    .q_1      (q1_r),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .add_b    (step_b),
    .add_cin  (step_cin),
    .a_nxt    (a_nxt),
    .q_nxt    (q_nxt),
    .q_1_nxt  (q1_nxt)
  );

  assign run       = (state == RUN);
  assign done      = (state == DONE);
  assign in_ready  = (state == IDLE);
  assign accept    = in_valid & in_ready;
  assign out_valid = done;
  assign adder_req = run;
  assign add_a     = run ? a_r    : '0;
  assign add_b     = run ? step_b : '0;
  assign add_cin   = run & step_cin;
  assign product   = done ? {a_r, q_r} : '0;
  assign overflow  = done & ~((&product[2*WIDTH-1:WIDTH-1]) | ~(|product[2*WIDTH-1:WIDTH-1]));

`ifdef Z_MULT_ZERO_BYPASS_EN
  assign zero_op = ~(|op_a) | ~(|op_b);
`else
  assign zero_op = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      a_r   <= '0;
      q_r   <= '0;
      m_r   <= '0;
      q1_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_r  <= '0;
          q1_r <= 1'b0;
          m_r  <= op_a;
          cnt  <= '0;
          if (zero_op) begin
            q_r   <= '0;
            state <= DONE;
          end else begin
            q_r   <= op_b;
            state <= RUN;
          end
        end
        RUN: begin
          a_r  <= a_nxt;
          q_r  <= q_nxt;
          q1_r <= q1_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH-1)) state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z_mult_booth_ctrl.sv
// Directed bench for z_mult_booth_ctrl with a behavioural model of the
// shared 32-bit adder; honours Z_MULT_ZERO_BYPASS_EN.
module tb_z_mult_booth_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [31:0] op_a, op_b;
  logic        out_valid, out_ready;
  logic [63:0] product;
  logic        overflow;
  logic        adder_req;
  logic [31:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;

  int compared = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  z_mult_booth_ctrl dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .overflow  (overflow),
    .adder_req (adder_req),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    logic        o;
    logic        early_ready;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " in_ready"},  64'(in_ready),  64'd1);
    chk({tag, " out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, " product"},   product,        64'd0);
    chk({tag, " overflow"},  64'(overflow),  64'd0);
    chk({tag, " adder_req"}, 64'(adder_req), 64'd0);
    chk({tag, " add_a"},     64'(add_a),     64'd0);
    chk({tag, " add_b"},     64'(add_b),     64'd0);
    chk({tag, " add_cin"},   64'(add_cin),   64'd0);
  endtask

  // Accept one operation, wait for out_valid, check it, optionally consume.
  task automatic start_and_wait(input logic [31:0] a, input logic [31:0] b,
                                input logic early_ready, output int lat,
                                output int adder_cycles);
    @(posedge clock); #1;
    op_a = a; op_b = b; in_valid = 1'b1; out_ready = early_ready;
    lat = 0; adder_cycles = 0;
    do begin
      @(posedge clock); #1;
      lat++;
      if (lat == 1) in_valid = 1'b0;
      if (adder_req) adder_cycles++;
    end while (!out_valid && lat < 100);
  endtask

  task automatic run_op(input string name, input vec_t v, input int exp_lat,
                        input int exp_adder);
    int lat, ac;
    start_and_wait(v.a, v.b, v.early_ready, lat, ac);
    chk({name, " latency"},     64'(lat),       64'(exp_lat));
    chk({name, " adder_cycles"},64'(ac),        64'(exp_adder));
    chk({name, " product"},     product,        v.p);
    chk({name, " overflow"},    64'(overflow),  64'(v.o));
    chk({name, " in_ready"},    64'(in_ready),  64'd0);
    chk({name, " done_add_b"},  64'(add_b),     64'd0);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk({name, " consumed"},    64'(out_valid), 64'd0);
    chk({name, " back_ready"},  64'(in_ready),  64'd1);
  endtask

  initial begin
    int lat, ac, zlat, zac;
    logic [63:0] held;

    vecs[0]  = '{32'd3,          32'd5,          64'd15,                   1'b0, 1'b1};
    vecs[1]  = '{32'hFFFF_FFF9,  32'd6,          64'hFFFF_FFFF_FFFF_FFD6,  1'b0, 1'b0};
    vecs[2]  = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000,  1'b1, 1'b0};
    vecs[3]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'd1,                    1'b0, 1'b0};
    vecs[4]  = '{32'h7FFF_FFFF,  32'd2,          64'h0000_0000_FFFF_FFFE,  1'b1, 1'b0};
    vecs[5]  = '{32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000,  1'b1, 1'b0};
    vecs[6]  = '{32'hFFFF_FFFF,  32'd1,          64'hFFFF_FFFF_FFFF_FFFF,  1'b0, 1'b0};
    vecs[7]  = '{32'h8000_0000,  32'd1,          64'hFFFF_FFFF_8000_0000,  1'b0, 1'b0};
    vecs[8]  = '{32'h8000_0000,  32'hFFFF_FFFF,  64'h0000_0000_8000_0000,  1'b1, 1'b0};
    vecs[9]  = '{32'h7FFF_FFFF,  32'h7FFF_FFFF,  64'h3FFF_FFFF_0000_0001,  1'b1, 1'b0};
    vecs[10] = '{32'h8000_0000,  32'h7FFF_FFFF,  64'hC000_0000_8000_0000,  1'b1, 1'b0};

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0;
    #12;
    chk_idle_outputs("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++)
      run_op($sformatf("vec%0d", i), vecs[i], 33, 32);

    // Stall in DONE: outputs hold, a new request is ignored.
    start_and_wait(32'd7, 32'hFFFF_FFFD, 1'b0, lat, ac);
    chk("stall latency", 64'(lat), 64'd33);
    held = product;
    chk("stall product", held, 64'hFFFF_FFFF_FFFF_FFEB);
    op_a = 32'd9; op_b = 32'd9; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      chk("stall hold_valid", 64'(out_valid), 64'd1);
      chk("stall hold_prod",  product,        held);
      chk("stall in_ready",   64'(in_ready),  64'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk("stall release_valid", 64'(out_valid), 64'd0);
    chk("stall release_ready", 64'(in_ready),  64'd1);

    // Reset in the middle of RUN, then a fresh operation.
    @(posedge clock); #1;
    op_a = 32'h1234_5678; op_b = 32'h0FED_CBA9; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clock);
    #3;
    chk("midrun adder_req", 64'(adder_req), 64'd1);
    reset_n = 1'b0;
    #1;
    chk_idle_outputs("midrun_reset");
    @(posedge clock); #1;
    reset_n = 1'b1;
    run_op("after_reset", '{32'd2, 32'd2, 64'd4, 1'b0, 1'b0}, 33, 32);

    // Zero operand: bypassed or full-length depending on build.
`ifdef Z_MULT_ZERO_BYPASS_EN
    zlat = 1; zac = 0;
`else
    zlat = 33; zac = 32;
`endif
    run_op("zero_a", '{32'd0, 32'h0000_1234, 64'd0, 1'b0, 1'b0}, zlat, zac);
    run_op("zero_b", '{32'h0000_1234, 32'd0, 64'd0, 1'b0, 1'b0}, zlat, zac);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
